// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and counter mode constants.
// The helpers work on a fixed maximum width; narrower values are zero-extended by the caller.
package gray_pkg;

  localparam int unsigned MODE_WRAP  = 0;
  localparam int unsigned MODE_SAT   = 1;
  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Zero upper bits contribute nothing to the prefix XOR, so any width <= GRAY_MAX_W works.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    for (int i = 0; i < GRAY_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or
// above it.
module gray2bin_conv #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  always_comb begin
    bin_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with parallel load, wrap or saturate ends, sticky end flags and a
// one-cycle Wrap pulse. Define GRAY_BIN_OUT_EN to expose the binary index on BinOut.
module gray_counter_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODE    = MODE_WRAP,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             En,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             ClrFlag,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow,
  output logic             Underflow,
  output logic             Wrap
`ifdef GRAY_BIN_OUT_EN
  ,
  output logic [WIDTH-1:0] BinOut
`endif
);

  // WIDTH must not exceed GRAY_MAX_W for the package helpers to cover it.
  localparam logic [WIDTH-1:0] MaxIdx  = '1;
  localparam logic [WIDTH-1:0] RstIdx  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RstGray = WIDTH'(bin2gray(GRAY_MAX_W'(RstIdx)));

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] load_bin;

  gray2bin_conv #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray_i(LoadVal),
    .bin_o (load_bin)
  );

  always_comb begin
    b_d    = b_q;
    ovf_d  = ovf_q & ~ClrFlag;
    unf_d  = unf_q & ~ClrFlag;
    wrap_d = 1'b0;
    if (Load) begin
      b_d = load_bin;
    end else if (En) begin
      if (Dir) begin
        if (b_q == MaxIdx) begin
          ovf_d  = 1'b1;
          wrap_d = 1'b1;
          if (MODE == MODE_WRAP) b_d = '0;
        end else begin
          b_d = b_q + 1'b1;
        end
      end else begin
        if (b_q == '0) begin
          unf_d  = 1'b1;
          wrap_d = 1'b1;
          if (MODE == MODE_WRAP) b_d = MaxIdx;
        end else begin
          b_d = b_q - 1'b1;
        end
      end
    end
    // Register the Gray value directly so Output never glitches through the XOR.
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(b_d)));
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      b_q    <= RstIdx;
      gray_q <= RstGray;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      b_q    <= b_d;
      gray_q <= gray_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  assign Output    = gray_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
  assign Wrap      = wrap_q;

`ifdef GRAY_BIN_OUT_EN
  assign BinOut = b_q;
`endif

endmodule
